// File: rtl/serial_subtractor.sv
// -----------------------------------------------------------------------------
// serial_subtractor
//
// Bit-serial unsigned subtractor computing (a - b) mod 2^WIDTH, one bit per
// clock, LSB first. Two half-subtractor stages are chained through a registered
// borrow flip-flop. A start/done handshake launches an operation and reports a
// registered difference and borrow-out.
//
// Ports:
//   clk    in   1      rising-edge clock
//   rst    in   1      synchronous, active-high reset
//   start  in   1      request a subtraction (honoured only while idle)
//   a      in   WIDTH  minuend, sampled on the accepting edge only
//   b      in   WIDTH  subtrahend, sampled on the accepting edge only
//   busy   out  1      high while an operation is running or completing
//   done   out  1      one-cycle pulse: diff/borrow were just updated
//   diff   out  WIDTH  registered (a - b) mod 2^WIDTH of the last operation
//   borrow out  1      registered borrow-out of the last operation (a < b)
// -----------------------------------------------------------------------------
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow
);

  localparam int             CW       = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0]  LAST_BIT = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] dacc_q, dacc_d;     // difference shift register
  logic             br_q, br_d;         // borrow flip-flop between bits
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic             borrow_q, borrow_d;

  // Per-bit datapath: two half-subtractors around the borrow flip-flop.
  logic             ai, bi, t, b1, d_bit, b2, br_next;
  logic [WIDTH:0]   dacc_wide;
  logic [WIDTH-1:0] dacc_shift;

  always_comb begin
    ai         = a_q[0];
    bi         = b_q[0];
    t          = ai ^ bi;
    b1         = ~ai & bi;
    d_bit      = t ^ br_q;
    b2         = ~t & br_q;
    br_next    = b1 | b2;
    // Shift the new bit in at the MSB; the wide form keeps WIDTH=1 legal.
    dacc_wide  = {d_bit, dacc_q};
    dacc_shift = dacc_wide[WIDTH:1];
  end

  // NOTE: every signal written here gets a default first, so no path leaves a
  // value unassigned and no latch can be inferred.
  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    dacc_d   = dacc_q;
    br_d     = br_q;
    cnt_d    = cnt_q;
    diff_d   = diff_q;
    borrow_d = borrow_q;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          a_d     = a;
          b_d     = b;
          dacc_d  = '0;
          br_d    = 1'b0;
          cnt_d   = '0;
          state_d = S_RUN;
        end
      end

      S_RUN: begin
        dacc_d = dacc_shift;
        a_d    = a_q >> 1;
        b_d    = b_q >> 1;
        br_d   = br_next;
        cnt_d  = cnt_q + CW'(1);
        if (cnt_q == LAST_BIT) begin
          // Final bit: publish the completed result on this same edge.
          diff_d   = dacc_shift;
          borrow_d = br_next;
          state_d  = S_DONE;
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      a_q      <= '0;
      b_q      <= '0;
      dacc_q   <= '0;
      br_q     <= 1'b0;
      cnt_q    <= '0;
      diff_q   <= '0;
      borrow_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      dacc_q   <= dacc_d;
      br_q     <= br_d;
      cnt_q    <= cnt_d;
      diff_q   <= diff_d;
      borrow_q <= borrow_d;
    end
  end

  // busy/done decode the state register directly, so they are glitch-free
  // and have no combinational path from the inputs.
  assign busy   = (state_q != S_IDLE);
  assign done   = (state_q == S_DONE);
  assign diff   = diff_q;
  assign borrow = borrow_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// -----------------------------------------------------------------------------
// tb_serial_subtractor
//
// Self-checking bench for serial_subtractor. An 8-bit and a 1-bit instance
// share clock and reset. Expected results are pushed to a per-instance queue
// when an operation is launched and popped by a monitor whenever done pulses.
// -----------------------------------------------------------------------------
module tb_serial_subtractor;

  logic       clk = 1'b0;
  logic       rst = 1'b1;

  logic       start8 = 1'b0;
  logic [7:0] a8 = '0, b8 = '0;
  logic       busy8, done8, borrow8;
  logic [7:0] diff8;

  logic       start1 = 1'b0;
  logic [0:0] a1 = '0, b1 = '0;
  logic       busy1, done1, borrow1;
  logic [0:0] diff1;

  int errors = 0;
  int checks = 0;
  int done8_cnt = 0;
  int done1_cnt = 0;

  logic [7:0] last_diff8 = '0;
  logic       last_borrow8 = 1'b0;

  typedef struct packed {
    logic [7:0] diff;
    logic       borrow;
  } exp8_t;

  typedef struct packed {
    logic [0:0] diff;
    logic       borrow;
  } exp1_t;

  exp8_t q8[$];
  exp1_t q1[$];
  exp8_t e8;
  exp1_t e1;

  serial_subtractor #(.WIDTH(8)) u_dut8 (
    .clk   (clk),
    .rst   (rst),
    .start (start8),
    .a     (a8),
    .b     (b8),
    .busy  (busy8),
    .done  (done8),
    .diff  (diff8),
    .borrow(borrow8)
  );

  serial_subtractor #(.WIDTH(1)) u_dut1 (
    .clk   (clk),
    .rst   (rst),
    .start (start1),
    .a     (a1),
    .b     (b1),
    .busy  (busy1),
    .done  (done1),
    .diff  (diff1),
    .borrow(borrow1)
  );

  always #5 clk = ~clk;

  // Scoreboard monitors: sample mid-cycle, pop one expectation per done pulse.
  always @(negedge clk) begin
    if (done8 === 1'b1) begin
      done8_cnt++;
      checks++;
      if (q8.size() == 0) begin
        errors++;
        $display("FAIL unexpected_done8: got done=1 with diff=%0d, required no pending op", diff8);
      end else begin
        e8 = q8.pop_front();
        if ({diff8, borrow8} !== {e8.diff, e8.borrow}) begin
          errors++;
          $display("FAIL result8: got diff=%0d borrow=%0b, required diff=%0d borrow=%0b",
                   diff8, borrow8, e8.diff, e8.borrow);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (done1 === 1'b1) begin
      done1_cnt++;
      checks++;
      if (q1.size() == 0) begin
        errors++;
        $display("FAIL unexpected_done1: got done=1, required no pending op");
      end else begin
        e1 = q1.pop_front();
        if ({diff1, borrow1} !== {e1.diff, e1.borrow}) begin
          errors++;
          $display("FAIL result1: got diff=%0b borrow=%0b, required diff=%0b borrow=%0b",
                   diff1, borrow1, e1.diff, e1.borrow);
        end
      end
    end
  end

  // Advance past the next rising edge; outputs are then read 1 ns later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Launch one 8-bit operation and check busy/done/result-hold cycle by cycle.
  task automatic run_op8(input logic [7:0] ai, input logic [7:0] bi);
    exp8_t exp;
    exp.diff   = ai - bi;
    exp.borrow = (ai < bi);
    a8 = ai;
    b8 = bi;
    start8 = 1'b1;
    q8.push_back(exp);
    tick();                                   // edge 0
    start8 = 1'b0;
    a8 = 8'($urandom);
    b8 = 8'($urandom);
    checks++;
    if (busy8 !== 1'b1 || done8 !== 1'b0) begin
      errors++;
      $display("FAIL op8_edge0(%0d-%0d): got busy=%0b done=%0b, required busy=1 done=0",
               ai, bi, busy8, done8);
    end
    for (int k = 1; k <= 9; k++) begin
      a8 = 8'($urandom);
      b8 = 8'($urandom);
      tick();                                 // edge k
      checks++;
      if (busy8 !== (k <= 8) || done8 !== (k == 8)) begin
        errors++;
        $display("FAIL op8_timing(%0d-%0d) edge %0d: got busy=%0b done=%0b, required busy=%0b done=%0b",
                 ai, bi, k, busy8, done8, (k <= 8), (k == 8));
      end
      if (k < 8) begin
        checks++;
        if (diff8 !== last_diff8 || borrow8 !== last_borrow8) begin
          errors++;
          $display("FAIL op8_hold_in_run edge %0d: got diff=%0d borrow=%0b, required diff=%0d borrow=%0b",
                   k, diff8, borrow8, last_diff8, last_borrow8);
        end
      end
    end
    last_diff8   = exp.diff;
    last_borrow8 = exp.borrow;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    start8 = 1'b1;
    start1 = 1'b1;
    a8 = 8'd200;
    b8 = 8'd1;
    tick();
    tick();
    checks++;
    if ({busy8, done8, diff8, borrow8} !== 11'b0) begin
      errors++;
      $display("FAIL reset8: got busy=%0b done=%0b diff=%0d borrow=%0b, required all 0",
               busy8, done8, diff8, borrow8);
    end
    checks++;
    if ({busy1, done1, diff1, borrow1} !== 4'b0) begin
      errors++;
      $display("FAIL reset1: got busy=%0b done=%0b diff=%0b borrow=%0b, required all 0",
               busy1, done1, diff1, borrow1);
    end
    start8 = 1'b0;
    start1 = 1'b0;
    rst = 1'b0;
    tick();
    checks++;
    if (busy8 !== 1'b0) begin
      errors++;
      $display("FAIL reset_idle8: got busy=%0b, required 0", busy8);
    end
  endtask

  task automatic test_basic();
    run_op8(8'd200, 8'd55);
  endtask

  task automatic test_underflow();
    run_op8(8'd5,   8'd9);
    run_op8(8'd0,   8'd0);
    run_op8(8'd255, 8'd255);
    run_op8(8'd0,   8'd1);
  endtask

  task automatic test_ignored_start();
    int    cnt0;
    exp8_t exp;
    cnt0 = done8_cnt;
    exp.diff   = 8'd70;
    exp.borrow = 1'b0;
    q8.push_back(exp);
    a8 = 8'd100;
    b8 = 8'd30;
    start8 = 1'b1;
    tick();                                   // edge 0
    for (int k = 1; k <= 9; k++) begin
      start8 = (k == 3 || k == 9);
      if (start8) begin
        a8 = 8'd1;
        b8 = 8'd2;
      end else begin
        a8 = 8'($urandom);
        b8 = 8'($urandom);
      end
      tick();                                 // edge k
    end
    start8 = 1'b0;
    repeat (12) tick();
    checks++;
    if (done8_cnt - cnt0 !== 1 || busy8 !== 1'b0) begin
      errors++;
      $display("FAIL ignored_start: got %0d done pulses busy=%0b, required 1 pulse busy=0",
               done8_cnt - cnt0, busy8);
    end
    last_diff8   = 8'd70;
    last_borrow8 = 1'b0;
  endtask

  task automatic test_reset_mid();
    int    cnt0;
    exp8_t exp;
    cnt0 = done8_cnt;
    a8 = 8'd77;
    b8 = 8'd7;
    start8 = 1'b1;
    tick();                                   // edge 0
    start8 = 1'b0;
    repeat (3) tick();                        // edges 1..3
    rst = 1'b1;
    tick();                                   // edge 4
    checks++;
    if ({busy8, done8, diff8, borrow8} !== 11'b0) begin
      errors++;
      $display("FAIL reset_mid: got busy=%0b done=%0b diff=%0d borrow=%0b, required all 0",
               busy8, done8, diff8, borrow8);
    end
    last_diff8   = '0;
    last_borrow8 = 1'b0;
    rst = 1'b0;
    tick();                                   // edge 5
    a8 = 8'd10;
    b8 = 8'd3;
    start8 = 1'b1;
    exp.diff   = 8'd7;
    exp.borrow = 1'b0;
    q8.push_back(exp);
    tick();                                   // edge 6
    start8 = 1'b0;
    for (int k = 7; k <= 15; k++) begin
      tick();
      checks++;
      if (done8 !== (k == 14) || busy8 !== (k <= 14)) begin
        errors++;
        $display("FAIL reset_mid_restart edge %0d: got busy=%0b done=%0b, required busy=%0b done=%0b",
                 k, busy8, done8, (k <= 14), (k == 14));
      end
    end
    checks++;
    if (done8_cnt - cnt0 !== 1) begin
      errors++;
      $display("FAIL reset_mid_pulses: got %0d done pulses, required 1", done8_cnt - cnt0);
    end
    last_diff8   = 8'd7;
    last_borrow8 = 1'b0;
  endtask

  task automatic test_hold_and_priority();
    for (int k = 0; k < 20; k++) begin
      a8 = 8'($urandom);
      b8 = 8'($urandom);
      tick();
      checks++;
      if (diff8 !== last_diff8 || borrow8 !== last_borrow8 || busy8 !== 1'b0) begin
        errors++;
        $display("FAIL hold cycle %0d: got diff=%0d borrow=%0b busy=%0b, required diff=%0d borrow=%0b busy=0",
                 k, diff8, borrow8, busy8, last_diff8, last_borrow8);
      end
    end
    rst = 1'b1;
    start8 = 1'b1;
    a8 = 8'd9;
    b8 = 8'd1;
    tick();
    rst = 1'b0;
    start8 = 1'b0;
    checks++;
    if (busy8 !== 1'b0 || done8 !== 1'b0 || diff8 !== 8'd0) begin
      errors++;
      $display("FAIL rst_priority: got busy=%0b done=%0b diff=%0d, required busy=0 done=0 diff=0",
               busy8, done8, diff8);
    end
    tick();
    checks++;
    if (busy8 !== 1'b0) begin
      errors++;
      $display("FAIL rst_priority_idle: got busy=%0b, required 0", busy8);
    end
    last_diff8   = '0;
    last_borrow8 = 1'b0;
  endtask

  task automatic test_width1();
    exp1_t exp;
    for (int i = 0; i < 4; i++) begin
      a1 = (i >> 1) & 1;
      b1 = i & 1;
      exp.diff   = a1 ^ b1;
      exp.borrow = ~a1[0] & b1[0];
      q1.push_back(exp);
      start1 = 1'b1;
      tick();                                 // edge 0
      start1 = 1'b0;
      a1 = ~a1;
      b1 = ~b1;
      checks++;
      if (busy1 !== 1'b1 || done1 !== 1'b0) begin
        errors++;
        $display("FAIL w1_edge0 case %0d: got busy=%0b done=%0b, required busy=1 done=0", i, busy1, done1);
      end
      tick();                                 // edge 1
      checks++;
      if (busy1 !== 1'b1 || done1 !== 1'b1) begin
        errors++;
        $display("FAIL w1_edge1 case %0d: got busy=%0b done=%0b, required busy=1 done=1", i, busy1, done1);
      end
      tick();                                 // edge 2
      checks++;
      if (busy1 !== 1'b0 || done1 !== 1'b0) begin
        errors++;
        $display("FAIL w1_edge2 case %0d: got busy=%0b done=%0b, required busy=0 done=0", i, busy1, done1);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_underflow();
    test_ignored_start();
    test_reset_mid();
    test_hold_and_priority();
    test_width1();
    repeat (4) tick();

    checks++;
    if (q8.size() != 0 || done8_cnt != 7) begin
      errors++;
      $display("FAIL drain8: got %0d pending, %0d dones, required 0 pending, 7 dones",
               q8.size(), done8_cnt);
    end
    checks++;
    if (q1.size() != 0 || done1_cnt != 4) begin
      errors++;
      $display("FAIL drain1: got %0d pending, %0d dones, required 0 pending, 4 dones",
               q1.size(), done1_cnt);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/serial_subtractor.md
# serial_subtractor

Bit-serial unsigned subtractor that computes `a - b` one bit per clock, LSB first. It is the inverse-direction companion to the combinational adder cells in the arithmetic library. Internally it chains two half-subtractor stages through a registered borrow flip-flop. It sits behind a simple start/done handshake, so a controller can issue operands and collect a registered difference and borrow-out without a full-width carry chain.

## Interface

Parameters:
- `WIDTH`, default 8: operand and result width in bits; legal range ≥ 1.

Ports:
- `clk`, input, 1: single clock; all state changes on its rising edge.
- `rst`, input, 1: reset, synchronous and active-high.
- `start`, input, 1: request a subtraction; honoured only in IDLE.
- `a`, input, WIDTH: minuend (unsigned); sampled on the accepting edge only.
- `b`, input, WIDTH: subtrahend (unsigned); sampled on the accepting edge only.
- `busy`, output, 1: high in RUN and DONE.
- `done`, output, 1: one-cycle pulse; result registers are valid and newly updated.
- `diff`, output, WIDTH: registered `(a - b) mod 2^WIDTH` of the last completed operation.
- `borrow`, output, 1: registered final borrow-out of the last completed operation; equals 1 iff `a < b`.

## Operation

**States:** IDLE, RUN, DONE.

**IDLE**
- If `start`=1 at the edge:
  - capture `a` and `b` into shift registers;
  - clear the borrow flip-flop;
  - clear the bit counter;
  - go to RUN.
- Otherwise stay in IDLE.

**RUN (one bit per cycle)**
- Per-bit logic, with `ai`/`bi` as the current LSBs and `br` as the borrow flip-flop:
  - stage 1: `t = ai ^ bi`, `b1 = ~ai & bi`;
  - stage 2: `d = t ^ br`, `b2 = ~t & br`;
  - `br_next = b1 | b2`.
- At each edge:
  - shift `d` into the MSB of the difference shift register;
  - shift both operand registers right by 1;
  - update `br`;
  - increment the counter.
- After the WIDTH-th bit is processed, go to DONE. On that same edge:
  - load `diff` from the completed difference register;
  - load `borrow` from `br_next`.

**DONE**
- `done`=1 for exactly one cycle, then go to IDLE.
- `start` is ignored in RUN and DONE. It is not queued; the requester must re-assert it in IDLE.

**Output behaviour**
- `diff` and `borrow` change only on the completing edge. They hold their value through IDLE and through the next RUN.
- Arithmetic is modulo 2^WIDTH. No signed interpretation and no saturation.
- `WIDTH`=1 is legal: RUN lasts exactly one cycle.

**Reset**
- `rst`=1 at any edge, including mid-RUN or in DONE: state goes to IDLE.
- All registers clear:
  - `busy`=0, `done`=0, `diff`=0, `borrow`=0;
  - internal shift registers, counter and borrow flip-flop = 0.
- An interrupted operation is discarded and produces no `done`.
- `rst` has priority over `start` in the same cycle.

## Timing

- Define edge 0 as the edge where `start`=1 is sampled in IDLE.
- `busy`: high from edge 0 through edge WIDTH+1; low after edge WIDTH+1.
- `diff`/`borrow` updated at edge WIDTH.
- `done`=1 during the cycle between edges WIDTH and WIDTH+1.
- Earliest next accepted `start`: edge WIDTH+2.
  - Throughput: one operation per WIDTH+2 cycles.
- Operand inputs may change freely after edge 0 without affecting the result.
- All outputs are registered. There is no combinational path from inputs to outputs.

## Test plan

1. **Basic subtraction.** `WIDTH`=8, `a`=200, `b`=55, `start` pulse at edge 0.
   - Required: `diff`=145, `borrow`=0.
   - `done` high only between edges 8 and 9; `busy` low after edge 9.
2. **Underflow wrap.** `a`=5, `b`=9.
   - Required: `diff`=252, `borrow`=1.
   - Then `a`=0, `b`=0 → `diff`=0, `borrow`=0.
   - Then `a`=255, `b`=255 → `diff`=0, `borrow`=0.
   - Then `a`=0, `b`=1 → `diff`=255, `borrow`=1.
3. **Ignored start and operand change.** Start with `a`=100, `b`=30.
   - At edges 3 and 9, re-assert `start` with `a`=1, `b`=2; change `a`/`b` every cycle.
   - Required: single `done`, `diff`=70, `borrow`=0, and no second operation.
4. **Reset mid-operation.** Start with `a`=77, `b`=7; assert `rst` at edge 4.
   - Required: all outputs 0 at edge 4; no `done` follows.
   - A fresh start at edge 6 with `a`=10, `b`=3 gives `done` between edges 14 and 15 with `diff`=7.
5. **Result hold and reset priority.** After a completed operation, hold `start`=0 for 20 cycles.
   - Required: `diff`/`borrow` unchanged.
   - `rst` and `start` high together → stays IDLE, `busy`=0.
6. **Single-bit width.** `WIDTH`=1, all four `a`/`b` combinations.
   - Required: `diff`=`a^b`, `borrow`=`~a&b`.
   - `done` between edges 1 and 2.
